sm4_result_serializer: RTL

//  Downstream stage of the two-lane SM4 group engine. Captures each finished 2-block result
//  (sm4_dout[255:0]) when the engine raises one_round_ok, streams it as 32-bit words over a

---
 rtl/sm4_result_serializer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sm4_result_serializer.sv
// sm4_result_serializer: captures a finished two-lane SM4 result and streams
// it as WORD_W-bit words over valid/ready, then pulses out_ok to the engine.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   one_round_ok    engine result ready (level, held until next send_ok)
//   sm4_dout        engine result, lane0=[127:0], lane1=[255:128]
//   end_group_num   index of the lane0 group in this result
//   all_group_num   total number of groups in the message
//   out_ok          one-cycle pulse once the result has been fully consumed
//   dout_data/valid/ready/last   output word stream, last marks message end
//   busy            high from capture until the engine drops one_round_ok
module sm4_result_serializer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int LANES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              one_round_ok,
    input  logic [383:0]      sm4_dout,
    input  logic [31:0]       end_group_num,
    input  logic [31:0]       all_group_num,
    output logic              out_ok,
    output logic [WORD_W-1:0] dout_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy
);

    localparam int WPB   = BLOCK_W / WORD_W;
    localparam int NW    = LANES * WPB;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int CAP_W = LANES * BLOCK_W;

    localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(WPB - 1);
    localparam logic [CNT_W-1:0] LAST_ALL = CNT_W'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_ACK,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [CAP_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   last_idx_q, last_idx_d;
    logic               final_q, final_d;

    logic               one_blk;
    logic               final_cap;
    logic [32:0]        end_ext;
    logic [32:0]        all_ext;
    logic [32:0]        end_plus;
    logic               xfer;
    logic [WORD_W-1:0]  words [NW];

    // The top third of the engine bus carries nothing for this stage.
    logic unused_hi;
    assign unused_hi = ^sm4_dout[383:CAP_W];

    // 33-bit compares so end_group_num near 2^32 cannot wrap.
    always_comb begin
        end_ext   = {1'b0, end_group_num};
        all_ext   = {1'b0, all_group_num};
        one_blk   = (end_ext + 33'd1) == all_ext;
        end_plus  = end_ext + (one_blk ? 33'd1 : 33'(LANES));
        final_cap = end_plus >= all_ext;
    end

    // Word i: lane i/WPB, most significant slice of the lane first.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            words[i] = data_q[(i / WPB) * BLOCK_W
                              + (WPB - 1 - (i % WPB)) * WORD_W +: WORD_W];
        end
    end

    assign dout_valid = (state_q == S_SEND);
    assign out_ok     = (state_q == S_ACK);
    assign busy       = (state_q != S_IDLE);
    assign dout_data  = dout_valid ? words[cnt_q] : '0;
    assign dout_last  = dout_valid & final_q & (cnt_q == last_idx_q);
    assign xfer       = dout_valid & dout_ready;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        final_d    = final_q;
        unique case (state_q)
            S_IDLE: begin
                if (one_round_ok) begin
                    data_d     = sm4_dout[CAP_W-1:0];
                    cnt_d      = '0;
                    last_idx_d = one_blk ? LAST_ONE : LAST_ALL;
                    final_d    = final_cap;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (cnt_q == last_idx_q) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ACK: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // Wait for the engine to drop the level so the same
                // result is never captured twice.
                if (!one_round_ok) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
            final_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            final_q    <= final_d;
        end
    end

endmodule
